// File: rtl/dm_byte_sync_if.sv
// Request/response bundle between the MEM stage and the data memory,
// plus the registered store-commit record used for the write log.
interface dm_byte_sync_if;
  logic [31:0] wpc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        misalign;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;

  modport master (
    output wpc, addr, wdata, we, re, size, sign_ext,
    input  rdata, rvalid, busy, misalign, log_valid, log_pc, log_addr, log_data
  );

  modport slave (
    input  wpc, addr, wdata, we, re, size, sign_ext,
    output rdata, rvalid, busy, misalign, log_valid, log_pc, log_addr, log_data
  );
endinterface

// File: rtl/dm_byte_sync.sv
// MEM-stage data memory: byte/half/word access with load extension, misalignment
// rejection, one-cycle registered read and a post-reset clearing sweep.
module dm_byte_sync #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          LOG_EN    = 1'b1
) (
  input logic           clk,
  input logic           reset,
  dm_byte_sync_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] clr_idx_r;
  logic [31:0]       mem_r [DEPTH];

  logic [31:0]       off_s;
  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        lane_s;
  logic              legal_s, accept_s, do_store_s, do_load_s, bad_s;
  logic [31:0]       cur_word_s, merged_s, load_s;

  logic [31:0] rdata_r, log_pc_r, log_addr_r, log_data_r;
  logic        rvalid_r, busy_r, misalign_r, log_valid_r;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (sz)
      2'b00:   res[{lane, 3'b000} +: 8]     = data[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16] = data[15:0];
      2'b10:   res = data;
      default: res = old_word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane,
                                              input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Upper offset bits fall away in the cast, so the word index wraps modulo DEPTH.
  assign off_s      = bus.addr - BASE_ADDR;
  assign idx_s      = ADDR_W'(off_s >> 2);
  assign lane_s     = off_s[1:0];
  assign accept_s   = (state_r == IDLE);
  assign do_store_s = accept_s & bus.we & legal_s;
  assign do_load_s  = accept_s & bus.re & legal_s;
  assign bad_s      = accept_s & (bus.we | bus.re) & ~legal_s;
  assign cur_word_s = mem_r[idx_s];
  assign merged_s   = merge_lanes(cur_word_s, bus.wdata, bus.size, lane_s);
  assign load_s     = load_extend(cur_word_s, bus.size, lane_s, bus.sign_ext);

  // Alignment rule per access size
  always_comb begin
    legal_s = 1'b0;
    case (bus.size)
      2'b00:   legal_s = 1'b1;
      2'b01:   legal_s = ~lane_s[0];
      2'b10:   legal_s = (lane_s == 2'b00);
      default: legal_s = 1'b0;
    endcase
  end

  // Next-state logic: sweep ends once the last index has been written
  always_comb begin
    state_nx_s = state_r;
    if (reset) begin
      state_nx_s = CLEAR;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_idx_r == {ADDR_W{1'b1}}) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = CLEAR;
          end
        end
        IDLE:    state_nx_s = IDLE;
        default: state_nx_s = CLEAR;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Sweep index
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx_r <= '0;
    end else if (state_r == CLEAR) begin
      clr_idx_r <= clr_idx_r + ADDR_W'(1);
    end else begin
      clr_idx_r <= clr_idx_r;
    end
  end

  // Storage array: sweep clear or read-modify-write store
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == CLEAR) begin
        mem_r[clr_idx_r] <= 32'h0000_0000;
      end else if (do_store_s) begin
        mem_r[idx_s] <= merged_s;
      end
    end
  end

  // Registered outputs; loads see the pre-store word because the array updates on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r     <= 32'h0000_0000;
      rvalid_r    <= 1'b0;
      busy_r      <= 1'b1;
      misalign_r  <= 1'b0;
      log_valid_r <= 1'b0;
      log_pc_r    <= 32'h0000_0000;
      log_addr_r  <= 32'h0000_0000;
      log_data_r  <= 32'h0000_0000;
    end else begin
      busy_r      <= (state_nx_s == CLEAR);
      rvalid_r    <= do_load_s;
      misalign_r  <= bad_s;
      log_valid_r <= LOG_EN & do_store_s;
      if (do_load_s) begin
        rdata_r <= load_s;
      end
      if (do_store_s) begin
        log_pc_r   <= bus.wpc;
        log_addr_r <= BASE_ADDR + 32'({idx_s, 2'b00});
        log_data_r <= merged_s;
      end
    end
  end

  assign bus.rdata     = rdata_r;
  assign bus.rvalid    = rvalid_r;
  assign bus.busy      = busy_r;
  assign bus.misalign  = misalign_r;
  assign bus.log_valid = log_valid_r;
  assign bus.log_pc    = log_pc_r;
  assign bus.log_addr  = log_addr_r;
  assign bus.log_data  = log_data_r;
endmodule
